// File: rtl/barycentric_interpolator_mc_if.sv
// Sample/result bus of the barycentric interpolator.
// Carries the pixel sample, triangle vertices, per-vertex attributes and the
// valid/ready handshakes on both sides.
//   master : pixel-sample source and fragment sink (drives valid_in, sample
//            data and ready_in; observes ready_out and the result signals).
//   slave  : the interpolator itself.
interface barycentric_interpolator_mc_if #(
  parameter int unsigned CHANNELS   = 3,
  parameter int unsigned VAL_WIDTH  = 16,
  parameter int unsigned AINV_WIDTH = 16,
  parameter int unsigned XWIDTH     = 16,
  parameter int unsigned YWIDTH     = 16
);
  // Input side
  logic                                    valid_in;
  logic                                    ready_out;
  logic signed [AINV_WIDTH-1:0]            iarea_in;
  logic signed [XWIDTH-1:0]                x_in;
  logic signed [YWIDTH-1:0]                y_in;
  logic [2:0][XWIDTH-1:0]                  x_tri;
  logic [2:0][YWIDTH-1:0]                  y_tri;
  logic [CHANNELS-1:0][2:0][VAL_WIDTH-1:0] vals_in;

  // Output side
  logic                                    valid_out;
  logic                                    ready_in;
  logic [CHANNELS-1:0][VAL_WIDTH-1:0]      inter_vals_out;
  logic                                    in_tri_out;
  logic [CHANNELS-1:0]                     ovf_out;

  modport master (
    output valid_in, iarea_in, x_in, y_in, x_tri, y_tri, vals_in, ready_in,
    input  ready_out, valid_out, inter_vals_out, in_tri_out, ovf_out
  );

  modport slave (
    input  valid_in, iarea_in, x_in, y_in, x_tri, y_tri, vals_in, ready_in,
    output ready_out, valid_out, inter_vals_out, in_tri_out, ovf_out
  );
endinterface

// File: rtl/barycentric_interpolator_mc.sv
// Multi-channel barycentric attribute interpolator.
// Computes the three edge functions of a sample against a triangle, derives
// the barycentric coefficients from the reciprocal edge total, tests
// inside/on-edge for either winding, and interpolates CHANNELS attributes.
// Register levels: differences, products, edges+inside, coefficients,
// per-channel products, sums, output. A single global enable stalls
// everything when the result is held by the sink.
// Ports:
//   clk_in : rising-edge clock
//   rst_in : synchronous active-high reset
//   bus    : slave side of barycentric_interpolator_mc_if (sample in, result out)
module barycentric_interpolator_mc #(
  parameter int unsigned CHANNELS     = 3,
  parameter int unsigned VAL_WIDTH    = 16,
  parameter int unsigned VAL_FRAC     = 14,
  parameter int unsigned AINV_WIDTH   = 16,
  parameter int unsigned AINV_FRAC    = 14,
  parameter int unsigned XWIDTH       = 16,
  parameter int unsigned YWIDTH       = 16,
  parameter int unsigned FRAC         = 14,
  parameter int unsigned SATURATE     = 1,
  parameter int unsigned CULL_OUTSIDE = 0
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  barycentric_interpolator_mc_if.slave bus
);

  localparam int unsigned DXW = XWIDTH + 1;          // x difference
  localparam int unsigned DYW = YWIDTH + 1;          // y difference
  localparam int unsigned PW  = DXW + DYW;           // difference product
  localparam int unsigned CRW = PW + 1;              // cross product
  localparam int unsigned EW  = CRW - FRAC;          // edge value after shift
  localparam int unsigned MW  = EW + AINV_WIDTH;     // edge * 1/E
  localparam int unsigned CW  = MW - AINV_FRAC;      // coefficient
  localparam int unsigned PRW = VAL_WIDTH + CW;      // attribute * coefficient
  localparam int unsigned SW  = PRW + 2;             // sum of three products
  localparam int unsigned RW  = SW - FRAC;           // unclamped result

  // Attributes share the coefficient fraction scaling, so the result keeps
  // the attribute format; reject parameter sets the clamp logic can't cover.
  if (RW <= VAL_WIDTH || VAL_FRAC >= VAL_WIDTH) begin : g_param_check
    $error("barycentric_interpolator_mc: unsupported width parameters");
  end

  typedef logic [CHANNELS-1:0][2:0][VAL_WIDTH-1:0] vals_t;

  // Stage valid bits and output register
  logic r_v1, r_v2, r_v3, r_v4, r_v5, r_v6, r_valid_o;
  logic w_en;

  // Stage data
  logic signed [DXW-1:0]        r_dx [3];
  logic signed [DYW-1:0]        r_dy [3];
  logic signed [PW-1:0]         r_pa [3];
  logic signed [PW-1:0]         r_pb [3];
  logic signed [EW-1:0]         r_e  [3];
  logic signed [CW-1:0]         r_c  [3];
  logic signed [PRW-1:0]        r_p  [CHANNELS][3];
  logic signed [SW-1:0]         r_sum [CHANNELS];
  logic signed [AINV_WIDTH-1:0] r_iarea1, r_iarea2, r_iarea3;
  vals_t                        r_vals1, r_vals2, r_vals3, r_vals4;
  logic                         r_in3, r_in4, r_in5, r_in6;
  logic [CHANNELS-1:0][VAL_WIDTH-1:0] r_out;
  logic                         r_in_o;
  logic [CHANNELS-1:0]          r_ovf;

  // Combinational stage inputs
  logic signed [DXW-1:0]  w_dx    [3];
  logic signed [DYW-1:0]  w_dy    [3];
  logic signed [PW-1:0]   w_pa    [3];
  logic signed [PW-1:0]   w_pb    [3];
  logic signed [CRW-1:0]  w_cross [3];
  logic signed [EW-1:0]   w_e     [3];
  logic signed [MW-1:0]   w_m     [3];
  logic signed [CW-1:0]   w_c     [3];
  logic signed [PRW-1:0]  w_prod  [CHANNELS][3];
  logic signed [SW-1:0]   w_sum   [CHANNELS];
  logic signed [RW-1:0]   w_r     [CHANNELS];
  logic [CHANNELS-1:0][VAL_WIDTH-1:0] w_out;
  logic [CHANNELS-1:0]    w_ovf;
  logic                   w_all_ge, w_all_le, w_in_tri, w_keep;

  // Global advance: the whole pipe moves unless a held result is blocked.
  assign w_en          = ~r_valid_o | bus.ready_in;
  assign bus.ready_out = w_en;

  // Edge datapath: differences, cross products, edge values, coefficients.
  for (genvar gi = 0; gi < 3; gi++) begin : g_edge
    localparam int unsigned J = (gi + 1) % 3;
    localparam int unsigned K = (gi + 2) % 3;
    logic signed [XWIDTH-1:0] w_xt;
    logic signed [YWIDTH-1:0] w_yt;
    assign w_xt        = bus.x_tri[gi];
    assign w_yt        = bus.y_tri[gi];
    assign w_dx[gi]    = DXW'(w_xt) - DXW'(bus.x_in);
    assign w_dy[gi]    = DYW'(w_yt) - DYW'(bus.y_in);
    assign w_pa[gi]    = PW'(r_dx[J]) * PW'(r_dy[K]);
    assign w_pb[gi]    = PW'(r_dx[K]) * PW'(r_dy[J]);
    assign w_cross[gi] = CRW'(r_pa[gi]) - CRW'(r_pb[gi]);
    assign w_e[gi]     = EW'(w_cross[gi] >>> FRAC);
    assign w_m[gi]     = MW'(r_e[gi]) * MW'(r_iarea3);
    assign w_c[gi]     = CW'(w_m[gi] >>> AINV_FRAC);
  end

  // Inside test, inclusive of edges, for either winding.
  always_comb begin
    w_all_ge = 1'b1;
    w_all_le = 1'b1;
    for (int i = 0; i < 3; i++) begin
      w_all_ge = w_all_ge & ~w_e[i][EW-1];
      w_all_le = w_all_le & (w_e[i][EW-1] | (w_e[i] == '0));
    end
    w_in_tri = w_all_ge | w_all_le;
  end

  assign w_keep = w_in_tri | (CULL_OUTSIDE == 0);

  // Channel datapath: products, sum, floor shift, clamp or wrap.
  for (genvar gc = 0; gc < CHANNELS; gc++) begin : g_chan
    logic [RW-VAL_WIDTH:0] w_hi;
    for (genvar gv = 0; gv < 3; gv++) begin : g_vert
      assign w_prod[gc][gv] = PRW'($signed(r_vals4[gc][gv])) * PRW'(r_c[gv]);
    end
    assign w_sum[gc] = SW'(r_p[gc][0]) + SW'(r_p[gc][1]) + SW'(r_p[gc][2]);
    assign w_r[gc]   = RW'(r_sum[gc] >>> FRAC);
    // In range only when every bit from the output sign upward agrees.
    assign w_hi      = w_r[gc][RW-1:VAL_WIDTH-1];
    assign w_ovf[gc] = ~(&w_hi | ~|w_hi);
    assign w_out[gc] = (SATURATE != 0 && w_ovf[gc])
                     ? {w_r[gc][RW-1], {(VAL_WIDTH-1){~w_r[gc][RW-1]}}}
                     : w_r[gc][VAL_WIDTH-1:0];
  end

  // Valid bits; culled samples lose their valid bit entering the edge stage.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      r_v3      <= 1'b0;
      r_v4      <= 1'b0;
      r_v5      <= 1'b0;
      r_v6      <= 1'b0;
      r_valid_o <= 1'b0;
    end else if (w_en) begin
      r_v1      <= bus.valid_in;
      r_v2      <= r_v1;
      r_v3      <= r_v2 & w_keep;
      r_v4      <= r_v3;
      r_v5      <= r_v4;
      r_v6      <= r_v5;
      r_valid_o <= r_v6;
    end
  end

  // Stage data registers; attributes and 1/E ride along with their sample.
  always_ff @(posedge clk_in) begin
    if (w_en) begin
      for (int i = 0; i < 3; i++) begin
        r_dx[i] <= w_dx[i];
        r_dy[i] <= w_dy[i];
        r_pa[i] <= w_pa[i];
        r_pb[i] <= w_pb[i];
        r_e[i]  <= w_e[i];
        r_c[i]  <= w_c[i];
      end
      for (int ch = 0; ch < CHANNELS; ch++) begin
        for (int v = 0; v < 3; v++) begin
          r_p[ch][v] <= w_prod[ch][v];
        end
        r_sum[ch] <= w_sum[ch];
      end
      r_iarea1 <= bus.iarea_in;
      r_iarea2 <= r_iarea1;
      r_iarea3 <= r_iarea2;
      r_vals1  <= bus.vals_in;
      r_vals2  <= r_vals1;
      r_vals3  <= r_vals2;
      r_vals4  <= r_vals3;
      r_in3    <= w_in_tri;
      r_in4    <= r_in3;
      r_in5    <= r_in4;
      r_in6    <= r_in5;
    end
  end

  // Output register: loads only real results so idle outputs stay put.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_out  <= '0;
      r_in_o <= 1'b0;
      r_ovf  <= '0;
    end else if (w_en && r_v6) begin
      r_out  <= w_out;
      r_in_o <= r_in6;
      r_ovf  <= w_ovf;
    end
  end

  assign bus.valid_out      = r_valid_o;
  assign bus.inter_vals_out = r_out;
  assign bus.in_tri_out     = r_in_o;
  assign bus.ovf_out        = r_ovf;

endmodule

// File: tb/tb_barycentric_interpolator_mc.sv
// Directed bench for barycentric_interpolator_mc: three instances share the
// stimulus (saturating, wrapping, culling) so each mode is observed on the
// same samples. Triangle (0,0),(1,0),(0,1) in Q2.14, 1/E = 1.0.
module tb_barycentric_interpolator_mc;
  localparam int unsigned CH = 3;
  localparam int unsigned VW = 16;
  typedef logic [CH-1:0][VW-1:0] out_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst_in;
  logic                     valid_in;
  logic                     ready_in;
  logic signed [15:0]       iarea;
  logic signed [15:0]       xs;
  logic signed [15:0]       ys;
  logic [2:0][15:0]         xt;
  logic [2:0][15:0]         yt;
  logic [CH-1:0][2:0][VW-1:0] vals;

  int checks = 0;
  int errors = 0;

  barycentric_interpolator_mc_if bus_s ();
  barycentric_interpolator_mc_if bus_w ();
  barycentric_interpolator_mc_if bus_c ();

  assign bus_s.valid_in = valid_in, bus_s.ready_in = ready_in, bus_s.iarea_in = iarea,
         bus_s.x_in = xs, bus_s.y_in = ys, bus_s.x_tri = xt, bus_s.y_tri = yt,
         bus_s.vals_in = vals;
  assign bus_w.valid_in = valid_in, bus_w.ready_in = ready_in, bus_w.iarea_in = iarea,
         bus_w.x_in = xs, bus_w.y_in = ys, bus_w.x_tri = xt, bus_w.y_tri = yt,
         bus_w.vals_in = vals;
  assign bus_c.valid_in = valid_in, bus_c.ready_in = ready_in, bus_c.iarea_in = iarea,
         bus_c.x_in = xs, bus_c.y_in = ys, bus_c.x_tri = xt, bus_c.y_tri = yt,
         bus_c.vals_in = vals;

  barycentric_interpolator_mc u_sat (.clk_in(clk), .rst_in(rst_in), .bus(bus_s));
  barycentric_interpolator_mc #(.SATURATE(0)) u_wrap (.clk_in(clk), .rst_in(rst_in), .bus(bus_w));
  barycentric_interpolator_mc #(.CULL_OUTSIDE(1)) u_cull (.clk_in(clk), .rst_in(rst_in), .bus(bus_c));

  // Stimulus helpers
  task automatic set_ch(input int ch, input int a0, input int a1, input int a2);
    vals[ch][0] = 16'(a0);
    vals[ch][1] = 16'(a1);
    vals[ch][2] = 16'(a2);
  endtask

  task automatic load_inside();  // (0.25,0.25): coefficients 0.5,0.25,0.25
    xs = 16'sd4096; ys = 16'sd4096;
    set_ch(0, 16384, 0, 0);
    set_ch(1, 8192, 16384, -16384);
    set_ch(2, 0, -1, 0);
  endtask

  task automatic load_outside(); // (1,1): coefficients -1,1,1
    xs = 16'sd16384; ys = 16'sd16384;
    set_ch(0, -28672, 28672, 28672);
    set_ch(1, 28672, -28672, -28672);
    set_ch(2, -28672, 28672, 28672);
  endtask

  task automatic load_vertex();  // exactly on vertex 1
    xs = 16'sd16384; ys = 16'sd0;
    set_ch(0, 100, -1234, 5);
    set_ch(1, 0, 32767, 0);
    set_ch(2, -7, -32768, 9);
  endtask

  task automatic load_stream(input int k); // results k, k, -k
    xs = 16'sd4096; ys = 16'sd4096;
    set_ch(0, 2 * k, 0, 0);
    set_ch(1, 0, 4 * k, 0);
    set_ch(2, 0, 0, -4 * k);
  endtask

  task automatic wait_out(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (bus_s.valid_out === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1; valid_in = 1'b0; ready_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_in = 1'b0;
    #1;
    checks++; if (bus_s.valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus_s.valid_out); end
    checks++; if (bus_s.ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus_s.ready_out); end
    checks++; if (bus_s.inter_vals_out !== '0) begin errors++; $display("FAIL reset_vals got %h exp 0", bus_s.inter_vals_out); end
    checks++; if (bus_s.ovf_out !== '0) begin errors++; $display("FAIL reset_ovf got %b exp 0", bus_s.ovf_out); end
    checks++; if (bus_s.in_tri_out !== 1'b0) begin errors++; $display("FAIL reset_in_tri got %b exp 0", bus_s.in_tri_out); end
  endtask

  task automatic test_inside();
    bit early;
    out_t exp_v;
    exp_v = {16'hFFFF, 16'd4096, 16'd8192};
    ready_in = 1'b1;
    load_inside();
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    early = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (bus_s.valid_out !== 1'b0) early = 1'b1;
      @(negedge clk);
    end
    checks++; if (early || bus_s.valid_out !== 1'b1) begin errors++; $display("FAIL latency early=%0d valid_out=%b exp early=0 valid_out=1", early, bus_s.valid_out); end
    checks++; if (bus_s.inter_vals_out !== exp_v) begin errors++; $display("FAIL inside_vals got %h exp %h", bus_s.inter_vals_out, exp_v); end
    checks++; if (bus_s.in_tri_out !== 1'b1) begin errors++; $display("FAIL inside_in_tri got %b exp 1", bus_s.in_tri_out); end
    checks++; if (bus_s.ovf_out !== 3'b000) begin errors++; $display("FAIL inside_ovf got %b exp 000", bus_s.ovf_out); end
    checks++; if (bus_w.inter_vals_out !== exp_v) begin errors++; $display("FAIL inside_wrap_vals got %h exp %h", bus_w.inter_vals_out, exp_v); end
    @(negedge clk);
    checks++; if (bus_s.valid_out !== 1'b0) begin errors++; $display("FAIL inside_nodup got %b exp 0", bus_s.valid_out); end
  endtask

  task automatic test_outside();
    bit ok;
    out_t exp_s, exp_w;
    exp_s = {16'h7FFF, 16'h8000, 16'h7FFF};
    exp_w = {16'h5000, 16'hB000, 16'h5000};
    ready_in = 1'b1;
    load_outside();
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    wait_out(12, ok);
    checks++; if (!ok) begin errors++; $display("FAIL outside_timeout got no valid_out exp valid_out within 12 cycles"); end
    checks++; if (bus_s.inter_vals_out !== exp_s) begin errors++; $display("FAIL outside_sat_vals got %h exp %h", bus_s.inter_vals_out, exp_s); end
    checks++; if (bus_s.in_tri_out !== 1'b0) begin errors++; $display("FAIL outside_in_tri got %b exp 0", bus_s.in_tri_out); end
    checks++; if (bus_s.ovf_out !== 3'b111) begin errors++; $display("FAIL outside_sat_ovf got %b exp 111", bus_s.ovf_out); end
    checks++; if (bus_w.inter_vals_out !== exp_w) begin errors++; $display("FAIL outside_wrap_vals got %h exp %h", bus_w.inter_vals_out, exp_w); end
    checks++; if (bus_w.ovf_out !== 3'b111) begin errors++; $display("FAIL outside_wrap_ovf got %b exp 111", bus_w.ovf_out); end
    checks++; if (bus_w.valid_out !== 1'b1) begin errors++; $display("FAIL outside_wrap_valid got %b exp 1", bus_w.valid_out); end
    checks++; if (bus_c.valid_out !== 1'b0) begin errors++; $display("FAIL outside_cull_valid got %b exp 0", bus_c.valid_out); end
    @(negedge clk);
  endtask

  task automatic test_vertex();
    bit ok;
    out_t exp_v;
    exp_v = {16'h8000, 16'h7FFF, 16'hFB2E};
    ready_in = 1'b1;
    load_vertex();
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    wait_out(12, ok);
    checks++; if (!ok) begin errors++; $display("FAIL vertex_timeout got no valid_out exp valid_out within 12 cycles"); end
    checks++; if (bus_s.inter_vals_out !== exp_v) begin errors++; $display("FAIL vertex_vals got %h exp %h", bus_s.inter_vals_out, exp_v); end
    checks++; if (bus_s.in_tri_out !== 1'b1) begin errors++; $display("FAIL vertex_in_tri got %b exp 1", bus_s.in_tri_out); end
    checks++; if (bus_s.ovf_out !== 3'b000) begin errors++; $display("FAIL vertex_ovf got %b exp 000", bus_s.ovf_out); end
    checks++; if (bus_c.valid_out !== 1'b1) begin errors++; $display("FAIL vertex_cull_valid got %b exp 1", bus_c.valid_out); end
    @(negedge clk);
  endtask

  task automatic test_cull();
    int   cnt_c, cnt_s;
    out_t got_c [4];
    cnt_c = 0; cnt_s = 0;
    for (int i = 0; i < 4; i++) got_c[i] = '0;
    ready_in = 1'b1;
    load_inside();  valid_in = 1'b1; @(negedge clk);
    load_outside(); @(negedge clk);
    load_vertex();  @(negedge clk);
    valid_in = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (bus_c.valid_out === 1'b1) begin
        if (cnt_c < 4) got_c[cnt_c] = bus_c.inter_vals_out;
        cnt_c++;
      end
      if (bus_s.valid_out === 1'b1) cnt_s++;
      @(negedge clk);
    end
    checks++; if (cnt_c != 2) begin errors++; $display("FAIL cull_count got %0d exp 2", cnt_c); end
    checks++; if (got_c[0] !== {16'hFFFF, 16'd4096, 16'd8192}) begin errors++; $display("FAIL cull_first got %h exp %h", got_c[0], {16'hFFFF, 16'd4096, 16'd8192}); end
    checks++; if (got_c[1] !== {16'h8000, 16'h7FFF, 16'hFB2E}) begin errors++; $display("FAIL cull_second got %h exp %h", got_c[1], {16'h8000, 16'h7FFF, 16'hFB2E}); end
    checks++; if (cnt_s != 3) begin errors++; $display("FAIL cull_pass_count got %0d exp 3", cnt_s); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pat;
    int   sent, got, cyc;
    bit   prev_stall;
    out_t prev_vals, exp_v;
    pat = 32'hB5C3_6E9A;
    sent = 0; got = 0; cyc = 0;
    prev_stall = 1'b0;
    prev_vals  = '0;
    while (got < 20 && cyc < 400) begin
      ready_in = pat[cyc % 32];
      if (sent < 20) begin
        valid_in = 1'b1;
        load_stream(sent + 1);
      end else begin
        valid_in = 1'b0;
      end
      #1;
      if (prev_stall) begin
        checks++;
        if (bus_s.valid_out !== 1'b1 || bus_s.inter_vals_out !== prev_vals) begin
          errors++; $display("FAIL stall_hold got valid=%b vals=%h exp valid=1 vals=%h", bus_s.valid_out, bus_s.inter_vals_out, prev_vals);
        end
      end
      if (bus_s.valid_out === 1'b1 && ready_in) begin
        got++;
        exp_v = {16'(-got), 16'(got), 16'(got)};
        checks++;
        if (bus_s.inter_vals_out !== exp_v) begin
          errors++; $display("FAIL stream_item%0d got %h exp %h", got, bus_s.inter_vals_out, exp_v);
        end
      end
      prev_stall = (bus_s.valid_out === 1'b1) && !ready_in;
      prev_vals  = bus_s.inter_vals_out;
      if (valid_in && bus_s.ready_out === 1'b1) sent++;
      @(negedge clk);
      cyc++;
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    checks++; if (got != 20) begin errors++; $display("FAIL stream_count got %0d exp 20", got); end
    checks++; if (bus_s.valid_out !== 1'b0) begin errors++; $display("FAIL stream_nodup got %b exp 0", bus_s.valid_out); end
  endtask

  task automatic test_reset_midstream();
    int stale;
    ready_in = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      load_stream(k);
      valid_in = 1'b1;
      @(negedge clk);
    end
    valid_in = 1'b0;
    rst_in   = 1'b1;
    @(negedge clk);
    rst_in = 1'b0;
    #1;
    checks++; if (bus_s.valid_out !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", bus_s.valid_out); end
    checks++; if (bus_s.in_tri_out !== 1'b0) begin errors++; $display("FAIL midrst_in_tri got %b exp 0", bus_s.in_tri_out); end
    checks++; if (bus_s.inter_vals_out !== '0) begin errors++; $display("FAIL midrst_vals got %h exp 0", bus_s.inter_vals_out); end
    checks++; if (bus_s.ready_out !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b exp 1", bus_s.ready_out); end
    stale = 0;
    repeat (12) begin
      if (bus_s.valid_out !== 1'b0 || bus_c.valid_out !== 1'b0) stale++;
      @(negedge clk);
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL midrst_stale got %0d stale cycles exp 0", stale); end
  endtask

  initial begin
    rst_in   = 1'b1;
    valid_in = 1'b0;
    ready_in = 1'b0;
    iarea    = 16'sd16384;
    xt       = {16'd0, 16'd16384, 16'd0};
    yt       = {16'd16384, 16'd0, 16'd0};
    xs       = '0;
    ys       = '0;
    vals     = '0;
    test_reset();
    test_inside();
    test_outside();
    test_vertex();
    test_cull();
    test_back_to_back();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion exp finish before 200000");
    $fatal(1, "watchdog");
  end
endmodule
